// File: rtl/room_occupancy_ctrl.sv
// Doorway beam-pair sequencer with saturating occupancy count.
// Synchronises and debounces both beams, then decodes walk-through order.
module room_occupancy_ctrl #(
    parameter int CW              = 5,
    parameter int MAX_COUNT       = 31,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sensor_out,
    input  logic          sensor_in,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          occupied,
    output logic          full,
    output logic          entry_pulse,
    output logic          exit_pulse,
    output logic          seq_error
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, E1, E2, E3, X1, X2, X3, WAIT_CLR
    } state_t;

    state_t         state, state_nxt;
    logic [1:0]     sync0, sync1, filt;
    logic [DW-1:0]  db_cnt [2];
    logic [1:0]     pair, pair_q;
    logic [TW-1:0]  tcnt;
    logic           active, changed, timeout;
    logic           commit_entry, commit_exit, err_nxt;

    // Index 1 is the corridor-side beam, index 0 the room-side beam.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= '0;
            sync1 <= '0;
        end else begin
            sync0 <= {sensor_out, sensor_in};
            sync1 <= sync0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt      <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (sync1[k] == filt[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    filt[k]   <= sync1[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign pair    = filt;
    assign changed = (pair != pair_q);
    assign active  = (state != IDLE) && (state != WAIT_CLR);
    assign timeout = active && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q <= '0;
            tcnt   <= '0;
        end else begin
            pair_q <= pair;
            if (!active || changed) tcnt <= '0;
            else                    tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = WAIT_CLR;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pair == 2'b10)      state_nxt = E1;
                    else if (pair == 2'b01) state_nxt = X1;
                    else if (pair == 2'b11) state_nxt = WAIT_CLR;
                end
                E1: begin
                    if (pair == 2'b11)      state_nxt = E2;
                    else if (pair == 2'b00) state_nxt = IDLE;
                end
                E2: begin
                    if (pair == 2'b01)      state_nxt = E3;
                    else if (pair == 2'b10) state_nxt = E1;
                    else if (pair == 2'b00) state_nxt = IDLE;
                end
                E3: begin
                    if (pair == 2'b00)      state_nxt = IDLE;
                    else if (pair == 2'b11) state_nxt = E2;
                end
                X1: begin
                    if (pair == 2'b11)      state_nxt = X2;
                    else if (pair == 2'b00) state_nxt = IDLE;
                end
                X2: begin
                    if (pair == 2'b10)      state_nxt = X3;
                    else if (pair == 2'b01) state_nxt = X1;
                    else if (pair == 2'b00) state_nxt = IDLE;
                end
                X3: begin
                    if (pair == 2'b00)      state_nxt = IDLE;
                    else if (pair == 2'b11) state_nxt = X2;
                end
                WAIT_CLR: begin
                    if (pair == 2'b00)      state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        commit_entry = (state == E3) && (state_nxt == IDLE);
        commit_exit  = (state == X3) && (state_nxt == IDLE);
        err_nxt      = ((state == IDLE) && (pair == 2'b11)) || timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            entry_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            entry_pulse <= commit_entry;
            exit_pulse  <= commit_exit;
            seq_error   <= err_nxt;
            // Clear wins over a same-cycle commit; the strobe still fires.
            if (clear)
                count <= '0;
            else if (commit_entry && (count < CW'(MAX_COUNT)))
                count <= count + 1'b1;
            else if (commit_exit && (count != '0))
                count <= count - 1'b1;
        end
    end

    assign occupied = (count != '0);
    assign full     = (count == CW'(MAX_COUNT));

endmodule
